// File: rtl/router_pkt_tx.sv
// Packet builder: buffers a host payload, then sends header, payload and XOR parity
// to the router, honouring the router's busy stall on every transmitted byte.
//
// state   | meaning
// IDLE    | waiting for a start request; bad requests pulse err
// LOAD    | accepting payload bytes from the host into the buffer
// HEADER  | driving {payload_len, dest_addr} until the router accepts it
// PAYLOAD | streaming buffered bytes back-to-back
// PARITY  | driving the XOR parity byte with pkt_valid low
module router_pkt_tx (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] payload_len,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY
    } state_t;

    state_t     state;
    logic [1:0] addr_q;
    logic [5:0] len_q;
    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr;
    logic [7:0] parity;
    logic [7:0] header;
    logic [7:0] buffer [0:63];

    assign header     = {len_q, addr_q};
    assign host_ready = (state == LOAD);
    assign tx_active  = (state != IDLE);

    // Buffer has no reset: an aborted packet leaves stale bytes that are simply overwritten.
    always_ff @(posedge clock) begin
        if (resetn && state == LOAD && host_valid) begin
            buffer[wr_ptr] <= host_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            addr_q    <= 2'd0;
            len_q     <= 6'd0;
            wr_ptr    <= 6'd0;
            rd_ptr    <= 6'd0;
            parity    <= 8'd0;
            data_out  <= 8'd0;
            pkt_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (dest_addr != 2'd3 && payload_len != 6'd0) begin
                            addr_q <= dest_addr;
                            len_q  <= payload_len;
                            parity <= {payload_len, dest_addr};
                            wr_ptr <= 6'd0;
                            state  <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (host_valid) begin
                        parity <= parity ^ host_data;
                        wr_ptr <= wr_ptr + 6'd1;
                        if (wr_ptr == len_q - 6'd1) begin
                            state     <= HEADER;
                            data_out  <= header;
                            pkt_valid <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        state    <= PAYLOAD;
                        data_out <= buffer[0];
                        rd_ptr   <= 6'd1;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        if (rd_ptr < len_q) begin
                            data_out <= buffer[rd_ptr];
                            rd_ptr   <= rd_ptr + 6'd1;
                        end else begin
                            state     <= PARITY;
                            data_out  <= parity;
                            pkt_valid <= 1'b0;
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        state    <= IDLE;
                        data_out <= 8'd0;
                        done     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
